// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              mm_req_i,
  input  logic              mm_we_i,
  input  logic [ADDR_W-1:0] mm_addr_i,
  input  logic [DATA_W-1:0] mm_wdata_i,
  output logic [DATA_W-1:0] mm_rdata_o,
  output logic              mm_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic owner_q, we_q, grant_mm, grant_if, last;
  // MM wins in IDLE; DONE can only hand the port to the other requester
  always_comb begin
    grant_mm = mm_req_i && (state_q == IDLE || (state_q == DONE && !owner_q));
    grant_if = if_req_i && ((state_q == IDLE && !mm_req_i) || (state_q == DONE && owner_q));
    last = state_q == WAIT && cnt_q <= 4'd1;
    cnt_d = state_q == ISSUE ? 4'(MEM_LATENCY) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    state_d = (grant_mm || grant_if) ? ISSUE : state_q == ISSUE ? WAIT : last ? DONE : state_q == DONE ? IDLE : state_q;
  end
  // state, latched access fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      busy_o <= 1'b0;
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      if_ready_o <= 1'b0;
      mm_ready_o <= 1'b0;
      if_rdata_o <= '0;
      mm_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_o <= state_d != IDLE;
      mem_en_o <= grant_mm || grant_if;
      mem_we_o <= grant_mm && mm_we_i;
      if_ready_o <= state_q == DONE && !owner_q;
      mm_ready_o <= state_q == DONE && owner_q;
      if (grant_mm || grant_if) begin
        owner_q <= grant_mm;
        we_q <= grant_mm && mm_we_i;
        mem_addr_o <= grant_mm ? mm_addr_i : if_addr_i;
        mem_wdata_o <= grant_mm ? mm_wdata_i : '0;
      end
      if (last && !owner_q) if_rdata_o <= mem_rdata_i;
      if (last && owner_q && !we_q) mm_rdata_o <= mem_rdata_i;
    end
  end
endmodule
